// File: rtl/dcache_plru_if.sv
// dcache_plru_if: control <-> PLRU victim-selector bundle.
//   master modport: the dcache controller (drives touches, queries, rready, clear)
//   slave  modport: the PLRU block (drives ready, response, busy)
interface dcache_plru_if #(
    parameter int INDEX_W = 6
);
    logic               ctrl2plru_touch_valid;
    logic [INDEX_W-1:0] ctrl2plru_touch_index;
    logic [2:0]         ctrl2plru_touch_way;
    logic               ctrl2plru_victim_valid;
    logic [INDEX_W-1:0] ctrl2plru_victim_index;
    logic               ctrl2plru_victim_vacancy_en;
    logic [2:0]         ctrl2plru_victim_vacancy_way;
    logic               plru2ctrl_victim_ready;
    logic               plru2ctrl_victim_rvalid;
    logic [2:0]         plru2ctrl_victim_way;
    logic               ctrl2plru_victim_rready;
    logic               ctrl2plru_clear;
    logic               plru2ctrl_busy;

    modport master (
        output ctrl2plru_touch_valid, ctrl2plru_touch_index, ctrl2plru_touch_way,
        output ctrl2plru_victim_valid, ctrl2plru_victim_index,
        output ctrl2plru_victim_vacancy_en, ctrl2plru_victim_vacancy_way,
        output ctrl2plru_victim_rready, ctrl2plru_clear,
        input  plru2ctrl_victim_ready, plru2ctrl_victim_rvalid,
        input  plru2ctrl_victim_way, plru2ctrl_busy
    );

    modport slave (
        input  ctrl2plru_touch_valid, ctrl2plru_touch_index, ctrl2plru_touch_way,
        input  ctrl2plru_victim_valid, ctrl2plru_victim_index,
        input  ctrl2plru_victim_vacancy_en, ctrl2plru_victim_vacancy_way,
        input  ctrl2plru_victim_rready, ctrl2plru_clear,
        output plru2ctrl_victim_ready, plru2ctrl_victim_rvalid,
        output plru2ctrl_victim_way, plru2ctrl_busy
    );
endinterface

// File: rtl/dcache_plru.sv
// dcache_plru: 8-way tree-PLRU victim selector, one 7-bit tree per set.
//   clock : posedge clock for all state
//   reset : asynchronous active-low reset
//   bus   : dcache_plru_if.slave -- touch port, victim query with one-cycle
//           held response, clear-sweep request and busy status.
// Tree bit b[i] names the side holding the LRU (0 left, 1 right); b0 is the
// root, b1/b2 the second level, b3..b6 the leaf pairs.
module dcache_plru #(
    parameter int INDEX_W = 6
) (
    input  logic          clock,
    input  logic          reset,
    dcache_plru_if.slave  bus
);
    localparam int SETS = 2 ** INDEX_W;
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(SETS - 1);
    localparam logic [INDEX_W-1:0] IDX_ONE  = INDEX_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Follow the LRU pointers from the root down to a leaf.
    function automatic logic [2:0] plru_victim(input logic [6:0] t);
        logic       w2;
        logic       w1;
        logic [2:0] leaf;
        w2   = t[0];
        w1   = w2 ? t[2] : t[1];
        leaf = 3'd3 + {1'b0, w2, w1};
        return {w2, w1, t[leaf]};
    endfunction

    // Point every node on the path of the accessed way away from it.
    function automatic logic [6:0] plru_touch(input logic [6:0] t, input logic [2:0] a);
        logic [6:0] n;
        logic [2:0] leaf;
        n    = t;
        n[0] = ~a[2];
        if (a[2]) begin
            n[2] = ~a[1];
        end else begin
            n[1] = ~a[1];
        end
        leaf    = 3'd3 + {1'b0, a[2], a[1]};
        n[leaf] = ~a[0];
        return n;
    endfunction

    state_t             state_r;
    logic [INDEX_W-1:0] cnt_r;
    logic [6:0]         tree_r [SETS];
    logic               busy_r;
    logic               rvalid_r;
    logic [2:0]         way_r;

    logic               ready_s;
    logic               accept_s;
    logic               touch_en_s;
    logic [6:0]         touched_s;
    logic [6:0]         query_tree_s;
    logic [2:0]         victim_s;

    // Handshake qualification, touch update and same-set bypass for the query.
    always_comb begin
        ready_s      = (state_r == ST_IDLE) && (!rvalid_r || bus.ctrl2plru_victim_rready);
        accept_s     = ready_s && bus.ctrl2plru_victim_valid;
        // A clear in the same cycle wins over the touch.
        touch_en_s   = (state_r == ST_IDLE) && bus.ctrl2plru_touch_valid && !bus.ctrl2plru_clear;
        touched_s    = plru_touch(tree_r[bus.ctrl2plru_touch_index], bus.ctrl2plru_touch_way);
        query_tree_s = tree_r[bus.ctrl2plru_victim_index];
        if (touch_en_s && (bus.ctrl2plru_touch_index == bus.ctrl2plru_victim_index)) begin
            query_tree_s = touched_s;
        end else begin
            query_tree_s = tree_r[bus.ctrl2plru_victim_index];
        end
        if (bus.ctrl2plru_victim_vacancy_en) begin
            victim_s = bus.ctrl2plru_victim_vacancy_way;
        end else begin
            victim_s = plru_victim(query_tree_s);
        end
    end

    // Mode FSM: touches in IDLE, one-set-per-cycle zeroing sweep in CLEAR.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            for (int i = 0; i < SETS; i++) begin
                tree_r[i] <= 7'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.ctrl2plru_clear) begin
                        state_r <= ST_CLEAR;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end else if (touch_en_s) begin
                        tree_r[bus.ctrl2plru_touch_index] <= touched_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    tree_r[cnt_r] <= 7'd0;
                    if (cnt_r == LAST_IDX) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + IDX_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Response register: loaded on accept, held until taken.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rvalid_r <= 1'b0;
            way_r    <= 3'd0;
        end else if (accept_s) begin
            rvalid_r <= 1'b1;
            way_r    <= victim_s;
        end else if (rvalid_r && bus.ctrl2plru_victim_rready) begin
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= rvalid_r;
        end
    end

    assign bus.plru2ctrl_victim_ready  = ready_s;
    assign bus.plru2ctrl_victim_rvalid = rvalid_r;
    assign bus.plru2ctrl_victim_way    = way_r;
    assign bus.plru2ctrl_busy          = busy_r;

endmodule

// File: tb/tb_dcache_plru.sv
// tb_dcache_plru: randomized + directed bench for dcache_plru with a
// queue scoreboard fed from a behavioural PLRU model.
module tb_dcache_plru;
    localparam int INDEX_W = 6;
    localparam int SETS    = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dcache_plru_if #(.INDEX_W(INDEX_W)) bus ();

    dcache_plru #(.INDEX_W(INDEX_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: tree bits per set, outstanding responses, sweep length left.
    bit [6:0] m_tree [SETS];
    bit       m_rvalid;
    int       m_busy_cnt;
    int       exp_q [$];

    function automatic int m_victim(bit [6:0] b);
        int w2, w1, w0;
        w2 = int'(b[0]);
        w1 = int'(b[1 + w2]);
        w0 = int'(b[3 + 2 * w2 + w1]);
        return 4 * w2 + 2 * w1 + w0;
    endfunction

    function automatic bit [6:0] m_touch(bit [6:0] b, int a);
        int a2, a1, a0;
        a2 = a / 4;
        a1 = (a / 2) % 2;
        a0 = a % 2;
        b[0]               = (a2 == 0);
        b[1 + a2]          = (a1 == 0);
        b[3 + 2 * a2 + a1] = (a0 == 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) m_tree[i] = 7'd0;
        m_rvalid   = 1'b0;
        m_busy_cnt = 0;
        exp_q.delete();
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: check held responses against the scoreboard head, pop when taken.
    always @(negedge clock) begin
        if (reset && bus.plru2ctrl_victim_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected got way %0d expected no response at %0t",
                         bus.plru2ctrl_victim_way, $time);
            end else begin
                chk("resp_way", int'(bus.plru2ctrl_victim_way), exp_q[0]);
                if (bus.ctrl2plru_victim_rready) void'(exp_q.pop_front());
            end
        end
    end

    // One clock: compare status outputs, advance the model, cross the edge.
    task automatic step();
        bit       exp_ready, acc, touch_eff;
        bit [6:0] t;
        int       ti, vi;
        @(negedge clock);
        exp_ready = (m_busy_cnt == 0) && (!m_rvalid || bus.ctrl2plru_victim_rready);
        chk("busy",   int'(bus.plru2ctrl_busy),          int'(m_busy_cnt != 0));
        chk("rvalid", int'(bus.plru2ctrl_victim_rvalid), int'(m_rvalid));
        chk("ready",  int'(bus.plru2ctrl_victim_ready),  int'(exp_ready));
        ti        = int'(bus.ctrl2plru_touch_index);
        vi        = int'(bus.ctrl2plru_victim_index);
        acc       = exp_ready && bus.ctrl2plru_victim_valid;
        touch_eff = bus.ctrl2plru_touch_valid && (m_busy_cnt == 0) && !bus.ctrl2plru_clear;
        if (acc) begin
            t = m_tree[vi];
            if (touch_eff && ti == vi) t = m_touch(t, int'(bus.ctrl2plru_touch_way));
            if (bus.ctrl2plru_victim_vacancy_en) exp_q.push_back(int'(bus.ctrl2plru_victim_vacancy_way));
            else                                 exp_q.push_back(m_victim(t));
        end
        if (acc)                                         m_rvalid = 1'b1;
        else if (m_rvalid && bus.ctrl2plru_victim_rready) m_rvalid = 1'b0;
        if (touch_eff) m_tree[ti] = m_touch(m_tree[ti], int'(bus.ctrl2plru_touch_way));
        if (m_busy_cnt > 0) begin
            m_busy_cnt--;
        end else if (bus.ctrl2plru_clear) begin
            // Touches are dropped and queries refused during the sweep, so the
            // only observable result is every set back at zero.
            m_busy_cnt = SETS;
            for (int i = 0; i < SETS; i++) m_tree[i] = 7'd0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive(bit tv, int ti, int tw, bit qv, int qi, bit vac, int vw, bit rr, bit clr);
        bus.ctrl2plru_touch_valid        = tv;
        bus.ctrl2plru_touch_index        = INDEX_W'(ti);
        bus.ctrl2plru_touch_way          = 3'(tw);
        bus.ctrl2plru_victim_valid       = qv;
        bus.ctrl2plru_victim_index       = INDEX_W'(qi);
        bus.ctrl2plru_victim_vacancy_en  = vac;
        bus.ctrl2plru_victim_vacancy_way = 3'(vw);
        bus.ctrl2plru_victim_rready      = rr;
        bus.ctrl2plru_clear              = clr;
        step();
    endtask

    task automatic touch(int idx, int way);
        drive(1'b1, idx, way, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic query(int idx);
        drive(1'b0, 0, 0, 1'b1, idx, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic idle(bit rr);
        drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, rr, 1'b0);
    endtask

    task automatic rand_cycle(int clear_odds);
        drive(1'($urandom_range(0, 1)), int'($urandom_range(0, SETS - 1)), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, SETS - 1)),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, clear_odds) == 0));
    endtask

    initial begin
        model_reset();
        bus.ctrl2plru_touch_valid        = 1'b0;
        bus.ctrl2plru_touch_index        = '0;
        bus.ctrl2plru_touch_way          = 3'd0;
        bus.ctrl2plru_victim_valid       = 1'b0;
        bus.ctrl2plru_victim_index       = '0;
        bus.ctrl2plru_victim_vacancy_en  = 1'b0;
        bus.ctrl2plru_victim_vacancy_way = 3'd0;
        bus.ctrl2plru_victim_rready      = 1'b0;
        bus.ctrl2plru_clear              = 1'b0;

        // Reset state.
        repeat (2) @(negedge clock);
        chk("reset_rvalid", int'(bus.plru2ctrl_victim_rvalid), 0);
        chk("reset_way",    int'(bus.plru2ctrl_victim_way),    0);
        chk("reset_busy",   int'(bus.plru2ctrl_busy),          0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // PLRU walk on set 5: 0, 4, 2, 6.
        query(5);
        touch(5, 0); query(5);
        touch(5, 4); query(5);
        touch(5, 2); query(5);

        // Same-cycle touch + query bypass, then vacancy override.
        drive(1'b1, 9, 3, 1'b1, 9, 1'b0, 0, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 1'b1, 9, 1'b1, 7, 1'b1, 1'b0);

        // Response hold with rready low, then accept on the releasing cycle.
        drive(1'b0, 0, 0, 1'b1, 5, 1'b0, 0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 0, 0, 1'b1, 9, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b1, 9, 1'b0, 0, 1'b1, 1'b0);
        idle(1'b1);

        // Full clear sweep with traffic thrown at it, then scan every set.
        touch(0, 5); touch(31, 2); touch(63, 7); touch(17, 1);
        drive(1'b1, 63, 0, 1'b1, 63, 1'b0, 0, 1'b1, 1'b1);
        repeat (SETS) rand_cycle(4);
        idle(1'b1);
        for (int i = 0; i < SETS; i++) query(i);
        idle(1'b1);

        // Reset in the middle of a sweep with a response pending.
        touch(40, 3); touch(50, 6); touch(63, 1);
        drive(1'b0, 0, 0, 1'b1, 40, 1'b0, 0, 1'b1, 1'b1);
        repeat (20) idle(1'b0);
        #3;
        reset = 1'b0;
        #1;
        chk("midsweep_rst_busy",   int'(bus.plru2ctrl_busy),          0);
        chk("midsweep_rst_rvalid", int'(bus.plru2ctrl_victim_rvalid), 0);
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        query(40); query(50); query(63); query(0);

        // Randomized traffic with occasional clears.
        repeat (1500) rand_cycle(250);

        // Drain.
        repeat (3) idle(1'b1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
